// File: rtl/pool2d_engine_if.sv
// Bus between the pooling engine and its feature-map memories and controller.
// master: the engine side; slave: the surrounding controller, input BRAM and output buffer.
interface pool2d_engine_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CONV_AW    = 13,
  parameter int POOL_AW    = 11
);
  logic                         start;
  logic                         mode;
  logic                         busy;
  logic                         done;
  logic [CONV_AW-1:0]           conv_addr;
  logic                         conv_en;
  logic signed [DATA_WIDTH-1:0] conv_q;
  logic [POOL_AW-1:0]           pool_addr;
  logic                         pool_en;
  logic                         pool_we;
  logic signed [DATA_WIDTH-1:0] pool_d;

  modport master (
    input  start, mode, conv_q,
    output busy, done, conv_addr, conv_en, pool_addr, pool_en, pool_we, pool_d
  );

  modport slave (
    output start, mode, conv_q,
    input  busy, done, conv_addr, conv_en, pool_addr, pool_en, pool_we, pool_d
  );
endinterface

// File: rtl/pool2d_engine.sv
// POOLxPOOL non-overlapping max/avg pooling of a CHW map held in a 1-cycle BRAM; one write
// every POOL*POOL+3 cycles, no backpressure. Define POOL_FUSED_RELU_EN to clamp results at zero.
module pool2d_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 8,
  parameter int IN_SIZE    = 28,
  parameter int POOL       = 2
) (
  input  logic           clk,
  input  logic           reset,
  pool2d_engine_if.master bus
);
  localparam int OUT_SIZE = IN_SIZE / POOL;
  localparam int LOG2P    = $clog2(POOL);
  localparam int SHIFT    = 2 * LOG2P;
  localparam int ACC_W    = DATA_WIDTH + SHIFT;
  localparam int CAW      = $clog2(CHANNELS * IN_SIZE * IN_SIZE);
  localparam int PAW      = $clog2(CHANNELS * OUT_SIZE * OUT_SIZE);
  localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int OS_W     = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int K_W      = (LOG2P > 0) ? LOG2P : 1;
  localparam int ROW_STEP = (POOL - 1) * IN_SIZE + POOL;
  localparam int KR_STEP  = IN_SIZE - POOL + 1;

  if (POOL < 2 || (POOL & (POOL - 1)) != 0) begin : g_pool_pow2
    $error("pool2d_engine: POOL must be a power of two >= 2");
  end
  if (IN_SIZE % POOL != 0) begin : g_pool_div
    $error("pool2d_engine: POOL must divide IN_SIZE");
  end

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_CAP, S_WRITE, S_FINISH} state_t;
  state_t state, state_nxt;

  logic                         busy_r, done_r, conv_en_r, pool_en_r, pool_we_r, mode_r;
  logic [CAW-1:0]               conv_addr_r, rd_ptr, win_base, win_next;
  logic [PAW-1:0]               pool_addr_r, pool_base;
  logic signed [DATA_WIDTH-1:0] pool_d_r, run_max, res_raw, result;
  logic signed [ACC_W-1:0]      acc, q_ext;
  logic                         first_r, smp_vld, smp_first;
  logic [K_W-1:0]               kr, kc;
  logic [OS_W-1:0]              col, row;
  logic [CH_W-1:0]              ch;
  logic                         last_k, last_col, last_row, last_out;

  assign last_k   = (kr == K_W'(POOL - 1)) && (kc == K_W'(POOL - 1));
  assign last_col = (col == OS_W'(OUT_SIZE - 1));
  assign last_row = (row == OS_W'(OUT_SIZE - 1));
  assign last_out = last_col && last_row && (ch == CH_W'(CHANNELS - 1));
  // The last column's row step lands exactly on the next pooled row (or next channel).
  assign win_next = last_col ? win_base + CAW'(ROW_STEP) : win_base + CAW'(POOL);
  assign q_ext    = ACC_W'(bus.conv_q);

  always_comb begin
    res_raw = mode_r ? DATA_WIDTH'(acc >>> SHIFT) : run_max;
`ifdef POOL_FUSED_RELU_EN
    result = res_raw[DATA_WIDTH-1] ? '0 : res_raw;
`else
    result = res_raw;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_READ;
      S_READ:   if (last_k) state_nxt = S_WAIT;
      S_WAIT:   state_nxt = S_CAP;
      S_CAP:    state_nxt = S_WRITE;
      S_WRITE:  state_nxt = last_out ? S_FINISH : S_READ;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      conv_en_r   <= 1'b0;
      conv_addr_r <= '0;
      pool_en_r   <= 1'b0;
      pool_we_r   <= 1'b0;
      pool_addr_r <= '0;
      pool_d_r    <= '0;
      mode_r      <= 1'b0;
      first_r     <= 1'b0;
      smp_vld     <= 1'b0;
      smp_first   <= 1'b0;
      run_max     <= '0;
      acc         <= '0;
      kr          <= '0;
      kc          <= '0;
      col         <= '0;
      row         <= '0;
      ch          <= '0;
      rd_ptr      <= '0;
      win_base    <= '0;
      pool_base   <= '0;
    end else begin
      conv_en_r <= 1'b0;
      first_r   <= 1'b0;
      pool_en_r <= 1'b0;
      pool_we_r <= 1'b0;
      done_r    <= 1'b0;
      // conv_q is valid the cycle after conv_en was visible; smp_* track that slot.
      smp_vld   <= conv_en_r;
      smp_first <= first_r;
      if (smp_vld) begin
        if (smp_first) begin
          run_max <= bus.conv_q;
          acc     <= q_ext;
        end else begin
          if (bus.conv_q > run_max) run_max <= bus.conv_q;
          acc <= acc + q_ext;
        end
      end

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            busy_r    <= 1'b1;
            mode_r    <= bus.mode;
            kr        <= '0;
            kc        <= '0;
            col       <= '0;
            row       <= '0;
            ch        <= '0;
            rd_ptr    <= '0;
            win_base  <= '0;
            pool_base <= '0;
          end
        end
        S_READ: begin
          conv_en_r   <= 1'b1;
          conv_addr_r <= rd_ptr;
          first_r     <= (kr == '0) && (kc == '0);
          if (kc == K_W'(POOL - 1)) begin
            kc     <= '0;
            kr     <= kr + K_W'(1);
            rd_ptr <= rd_ptr + CAW'(KR_STEP);
          end else begin
            kc     <= kc + K_W'(1);
            rd_ptr <= rd_ptr + CAW'(1);
          end
        end
        S_WRITE: begin
          pool_en_r   <= 1'b1;
          pool_we_r   <= 1'b1;
          pool_d_r    <= result;
          pool_addr_r <= pool_base;
          pool_base   <= pool_base + PAW'(1);
          win_base    <= win_next;
          rd_ptr      <= win_next;
          if (last_col) begin
            col <= '0;
            if (last_row) begin
              row <= '0;
              ch  <= ch + CH_W'(1);
            end else begin
              row <= row + OS_W'(1);
            end
          end else begin
            col <= col + OS_W'(1);
          end
        end
        S_FINISH: begin
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.conv_en   = conv_en_r;
  assign bus.conv_addr = conv_addr_r;
  assign bus.pool_en   = pool_en_r;
  assign bus.pool_we   = pool_we_r;
  assign bus.pool_addr = pool_addr_r;
  assign bus.pool_d    = pool_d_r;
endmodule

// File: tb/tb_pool2d_engine.sv
// Directed bench for pool2d_engine: three geometries (1ch 4x4 P2, 2ch 8x8 P4, 3ch 4x4 P2),
// a vector table of full passes plus mid-pass start and mid-pass reset sequences.
module tb_pool2d_engine;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pool2d_engine_if #(.DATA_WIDTH(16), .CONV_AW(4), .POOL_AW(2)) if_a ();
  pool2d_engine_if #(.DATA_WIDTH(16), .CONV_AW(7), .POOL_AW(3)) if_b ();
  pool2d_engine_if #(.DATA_WIDTH(16), .CONV_AW(6), .POOL_AW(4)) if_c ();

  pool2d_engine #(.DATA_WIDTH(16), .CHANNELS(1), .IN_SIZE(4), .POOL(2)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.master));
  pool2d_engine #(.DATA_WIDTH(16), .CHANNELS(2), .IN_SIZE(8), .POOL(4)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b.master));
  pool2d_engine #(.DATA_WIDTH(16), .CHANNELS(3), .IN_SIZE(4), .POOL(2)) dut_c (
    .clk(clk), .reset(reset), .bus(if_c.master));

  logic signed [15:0] mem_a [16];
  logic signed [15:0] mem_b [128];
  logic signed [15:0] mem_c [48];

  always @(posedge clk) begin
    if (if_a.conv_en) if_a.conv_q <= mem_a[if_a.conv_addr];
    if (if_b.conv_en) if_b.conv_q <= mem_b[if_b.conv_addr];
    if (if_c.conv_en) if_c.conv_q <= mem_c[if_c.conv_addr];
  end

  // Write/done log per instance, sampled on the falling edge.
  int w_addr [3][64];
  int w_dat  [3][64];
  int w_cyc  [3][64];
  int wn [3] = '{0, 0, 0};
  int dn [3] = '{0, 0, 0};
  int d_cyc [3] = '{0, 0, 0};
  int ov [3] = '{0, 0, 0};
  int rd_log [256];
  int rn = 0;

  task automatic mon(input int w, input bit we, input int a, input int d, input bit dn_i, input bit ce);
    if (we && wn[w] < 64) begin
      w_addr[w][wn[w]] <= a;
      w_dat[w][wn[w]]  <= d;
      w_cyc[w][wn[w]]  <= cyc;
      wn[w]            <= wn[w] + 1;
    end
    if (dn_i) begin
      dn[w]    <= dn[w] + 1;
      d_cyc[w] <= cyc;
    end
    if (ce && we) ov[w] <= ov[w] + 1;
  endtask

  always @(negedge clk) begin
    mon(0, if_a.pool_we, int'(if_a.pool_addr), int'(if_a.pool_d), if_a.done, if_a.conv_en);
    mon(1, if_b.pool_we, int'(if_b.pool_addr), int'(if_b.pool_d), if_b.done, if_b.conv_en);
    mon(2, if_c.pool_we, int'(if_c.pool_addr), int'(if_c.pool_d), if_c.done, if_c.conv_en);
    if (if_b.conv_en && rn < 256) begin
      rd_log[rn] <= int'(if_b.conv_addr);
      rn         <= rn + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int relu(input int x);
`ifdef POOL_FUSED_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic int get_busy(input int w);
    case (w)
      0:       return int'(if_a.busy);
      1:       return int'(if_b.busy);
      default: return int'(if_c.busy);
    endcase
  endfunction

  task automatic set_in(input int w, input bit s, input bit m);
    case (w)
      0:       begin if_a.start = s; if_a.mode = m; end
      1:       begin if_b.start = s; if_b.mode = m; end
      default: begin if_c.start = s; if_c.mode = m; end
    endcase
  endtask

  task automatic load_map(input int map);
    case (map)
      0, 1: begin
        for (int i = 0; i < 16; i++) mem_a[i] = 16'(i);
        if (map == 1) begin
          mem_a[0] = -16'sd1;
          mem_a[1] = -16'sd2;
          mem_a[4] = -16'sd3;
          mem_a[5] = -16'sd5;
        end
      end
      2: begin
        for (int i = 0; i < 128; i++) mem_b[i] = 16'((i % 7) - 3);
        for (int c = 0; c < 2; c++)
          for (int r = 0; r < 2; r++)
            for (int k = 0; k < 2; k++)
              mem_b[c*64 + (r*4+3)*8 + k*4 + 3] = 16'(100 + c*4 + r*2 + k);
      end
      default: for (int i = 0; i < 48; i++) mem_c[i] = 16'(i - 50);
    endcase
  endtask

  typedef struct {
    int inst;
    int map;
    bit mode;
    int nwr;
    int exp_d [12];
  } vec_t;
  vec_t vecs [6];

  int w0_s, d0_s, ov0_s;

  task automatic begin_vec(input vec_t v);
    w0_s  = wn[v.inst];
    d0_s  = dn[v.inst];
    ov0_s = ov[v.inst];
    set_in(v.inst, 1'b1, v.mode);
    tick();
    set_in(v.inst, 1'b0, v.mode);
  endtask

  task automatic finish_vec(input vec_t v, input string tag);
    int spc;
    int last;
    int i;
    spc = (v.inst == 1) ? 19 : 7;
    for (i = 0; i < 1000 && dn[v.inst] == d0_s; i++) tick();
    check({tag, "_done_seen"}, int'(dn[v.inst] != d0_s), 1);
    check({tag, "_done_cnt"}, dn[v.inst] - d0_s, 1);
    check({tag, "_wr_cnt"}, wn[v.inst] - w0_s, v.nwr);
    for (int k = 0; k < v.nwr && w0_s + k < 64; k++) begin
      check($sformatf("%s_dat%0d", tag, k), w_dat[v.inst][w0_s+k], relu(v.exp_d[k]));
      check($sformatf("%s_adr%0d", tag, k), w_addr[v.inst][w0_s+k], k);
      if (k > 0)
        check($sformatf("%s_gap%0d", tag, k), w_cyc[v.inst][w0_s+k] - w_cyc[v.inst][w0_s+k-1], spc);
    end
    last = w0_s + v.nwr - 1;
    if (last >= 0 && last < 64)
      check({tag, "_done_lat"}, d_cyc[v.inst] - w_cyc[v.inst][last], 1);
    check({tag, "_overlap"}, ov[v.inst] - ov0_s, 0);
    check({tag, "_busy_end"}, get_busy(v.inst), 0);
  endtask

  task automatic check_zero_a(input string pfx);
    check({pfx, "_busy"},      int'(if_a.busy), 0);
    check({pfx, "_done"},      int'(if_a.done), 0);
    check({pfx, "_conv_en"},   int'(if_a.conv_en), 0);
    check({pfx, "_conv_addr"}, int'(if_a.conv_addr), 0);
    check({pfx, "_pool_en"},   int'(if_a.pool_en), 0);
    check({pfx, "_pool_we"},   int'(if_a.pool_we), 0);
    check({pfx, "_pool_addr"}, int'(if_a.pool_addr), 0);
    check({pfx, "_pool_d"},    int'(if_a.pool_d), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, db, w1, idx;
    vecs[0] = '{0, 0, 1'b0, 4,  '{5, 7, 13, 15, 0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[1] = '{0, 1, 1'b1, 4,  '{-3, 4, 10, 12, 0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[2] = '{0, 1, 1'b0, 4,  '{-1, 7, 13, 15, 0, 0, 0, 0, 0, 0, 0, 0}};
    vecs[3] = '{2, 3, 1'b0, 12, '{-45, -43, -37, -35, -29, -27, -21, -19, -13, -11, -5, -3}};
    vecs[4] = '{2, 3, 1'b1, 12, '{-48, -46, -40, -38, -32, -30, -24, -22, -16, -14, -8, -6}};
    vecs[5] = '{1, 2, 1'b0, 8,  '{100, 101, 102, 103, 104, 105, 106, 107, 0, 0, 0, 0}};

    reset = 1'b1;
    for (int w = 0; w < 3; w++) set_in(w, 1'b0, 1'b0);
    repeat (3) tick();
    check_zero_a("rst");
    check("rst_busy_b", get_busy(1), 0);
    check("rst_busy_c", get_busy(2), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      load_map(vecs[i].map);
      begin_vec(vecs[i]);
      finish_vec(vecs[i], $sformatf("v%0d", i));
    end

    check("b_rd_cnt", rn, 128);
    idx = 0;
    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 2; r++)
        for (int k = 0; k < 2; k++)
          for (int kr = 0; kr < 4; kr++)
            for (int kc = 0; kc < 4; kc++) begin
              if (idx < rn)
                check($sformatf("b_rd%0d", idx), rd_log[idx], c*64 + (r*4+kr)*8 + k*4 + kc);
              idx++;
            end

    // Start pulse with the opposite mode while busy must not disturb the pass.
    load_map(0);
    begin_vec(vecs[0]);
    repeat (4) tick();
    check("mid_busy", get_busy(0), 1);
    set_in(0, 1'b1, 1'b1);
    tick();
    set_in(0, 1'b0, 1'b1);
    finish_vec(vecs[0], "mid");
    w1 = wn[0];
    db = dn[0];
    repeat (20) tick();
    check("mid_no_restart", wn[0] - w1, 0);
    check("mid_no_done", dn[0] - db, 0);
    set_in(0, 1'b0, 1'b0);

    // Reset during the second window's reads.
    begin_vec(vecs[0]);
    wb = w0_s;
    db = d0_s;
    for (int i = 0; i < 50 && wn[0] == wb; i++) tick();
    check("abort_first_wr", wn[0] - wb, 1);
    tick();
    check("abort_reading", int'(if_a.conv_en), 1);
    reset = 1'b1;
    tick();
    check_zero_a("abort");
    reset = 1'b0;
    repeat (30) tick();
    check("abort_no_more_wr", wn[0] - wb, 1);
    check("abort_no_done", dn[0] - db, 0);
    check("abort_idle", get_busy(0), 0);
    begin_vec(vecs[0]);
    finish_vec(vecs[0], "fresh");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pool2d_engine.md
Name: pool2d_engine

Overview:
- Generalised K×K non-overlapping pooling layer (stride = POOL) for CNN feature maps.
- Supports runtime-selectable max or average mode.
- Reads a CHW-linear feature map from a 1-cycle-latency BRAM and writes the pooled CHW-linear map to the output buffer.
- Drop-in for conv→pool stages with any power-of-two pool factor.

Parameters:
- DATA_WIDTH, 16, signed activation width
- CHANNELS, 8, number of channels (≥1)
- IN_SIZE, 28, input H=W; must be divisible by POOL
- POOL, 2, window size and stride; power of two in {2,4,8}

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  begin a full-map pass; sampled only in IDLE
- mode  in  1  0=max, 1=average; latched at accepted start
- busy  out  1  high from accepted start until done
- conv_addr  out  $clog2(CHANNELS*IN_SIZE²)  input read address
- conv_en  out  1  input read enable
- conv_q  in  DATA_WIDTH  signed read data, valid one cycle after conv_en
- pool_addr  out  $clog2(CHANNELS*(IN_SIZE/POOL)²)  output write address
- pool_en  out  1  output enable
- pool_we  out  1  output write strobe
- pool_d  out  DATA_WIDTH  signed result
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- Clocking and reset: reset is synchronous, active-high; clock is clk. Reset values: all outputs 0; state IDLE; indices, pointers and accumulator cleared.
- Reset mid-pass: abort immediately to IDLE. No done pulse, no further writes.
- OUT_SIZE = IN_SIZE/POOL. Compile-time $error if POOL is not a power of two or does not divide IN_SIZE.
- Output definition: out[ch,r,c] uses window in[ch, r·POOL+kr, c·POOL+kc], for kr,kc ∈ [0,POOL).
- Window read order: kr outer, kc inner.
- Outer output order: channel, then row, then column. pool_addr increments by 1 per output, starting at 0.
- Addressing:
  - Incremental base pointers only; no runtime multipliers.
  - Next column: +POOL.
  - Next pooled row: +(POOL−1)·IN_SIZE + POOL.
  - Next channel: the same row step, which lands on channel start because rows are contiguous.
  - Within a window: +1 per kc; at end of a window row, +IN_SIZE−POOL+1.
- FSM:
  - IDLE: on start, latch mode, clear indices and pointers, assert busy → READ.
  - READ: register one read per cycle for POOL² consecutive cycles → WAIT.
  - WAIT: one cycle for the last read's BRAM latency → CAP.
  - CAP: capture the final sample → WRITE.
  - WRITE: register pool_en=pool_we=1, pool_d=result, pool_addr=pool_base; advance indices. Go to READ, or to FINISH after the last output of the last channel.
  - FINISH: done=1 for one cycle, busy=0 → IDLE.
- Data capture: every sample is captured the cycle after its conv_en is visible. Captures overlap READ; no bubbles between reads.
- Timing:
  - Consecutive pool_we pulses within a pass are exactly POOL²+3 cycles apart.
  - done is high the cycle after the final pool_we pulse.
- Max mode: signed running compare. The first sample of each window initialises the running max; no reset-value bias.
- Average mode:
  - Signed accumulator of width DATA_WIDTH+2·log2(POOL); no overflow possible.
  - Result = acc >>> 2·log2(POOL), an arithmetic shift (floor toward −∞), truncated to DATA_WIDTH. The truncation is always in range.
- start while busy: ignored. mode changes mid-pass: ignored.
- conv_en and pool_we are never asserted in the same cycle. conv_en is never asserted outside READ-issued cycles.

Optional Feature:
- Macro POOL_FUSED_RELU_EN.
- Defined: the final result is clamped, max(result, 0), before pool_d in both modes. This adds no latency.
- Undefined: results are written unmodified, and negative outputs are allowed.

Test Plan:
- CHANNELS=1, IN_SIZE=4, POOL=2, max, input 0..15 ramp → writes 5,7,13,15 at addr 0..3; done one cycle after the 4th pool_we; pool_we spacing 7 cycles.
- Same map, avg mode, window {−1,−2,−3,−5} at top-left → sum −11, pool_d = −3 (floor), not −2.
- POOL=4, IN_SIZE=8, CHANNELS=2, max, distinct maximum placed at the bottom-right of each window → 8 writes, each equal to the planted max; conv_addr sequence matches the kr-outer/kc-inner order.
- CHANNELS=3 all-negative map, max mode → max is the least-negative value, not 0. With POOL_FUSED_RELU_EN defined → all writes 0.
- Pulse start mid-pass with mode toggled → no restart; the pass completes in the original mode with the same write count.
- Assert reset during the 2nd window's READ → all outputs 0 next cycle, no done. A fresh start then produces the correct full sequence from addr 0.
